// File: rtl/mxm_pkg.sv
// Shared MxM definitions: default dimensions, feeder FSM state type and a width helper.
// Used by the operand feeder, its index counter and the downstream MxM/result logic.
package mxm_pkg;

    localparam int W_DEF = 8;
    localparam int N_DEF = 1000;
    localparam int M_DEF = 4;
    localparam int P_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } feed_state_t;

    // Bits needed to index v items; never below 1 so degenerate dimensions still get a port.
    function automatic int log2(input int v);
        int r;
        r = 1;
        for (int b = 1; b < 31; b++) begin
            if ((1 << b) < v) begin
                r = b + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mxm_idx_counter.sv
// Nested k/j/i walker producing A and X read addresses incrementally (no multipliers).
// MXM_FEED_XCOL_EN selects column-major X storage (x_addr = j*N+k) instead of row-major (k*P+j).
module mxm_idx_counter
    import mxm_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int M  = M_DEF,
    parameter int P  = P_DEF,
    parameter int AW = log2(M * N),
    parameter int XW = log2(N * P),
    parameter int IW = log2(M),
    parameter int JW = log2(P),
    parameter int KW = log2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [AW-1:0] a_addr,
    output logic [XW-1:0] x_addr,
    output logic [IW-1:0] i,
    output logic [JW-1:0] j,
    output logic          k_last,
    output logic          last
);

`ifdef MXM_FEED_XCOL_EN
    localparam int XSTEP = 1;
`else
    localparam int XSTEP = P;
`endif

    logic [KW-1:0] k_reg;
    logic [JW-1:0] j_reg;
    logic [IW-1:0] i_reg;
    logic [AW-1:0] a_addr_reg;
    logic [AW-1:0] a_base_reg;
    logic [XW-1:0] x_addr_reg;
    logic          j_last;
    logic          i_last;

    assign k_last = (k_reg == KW'(N - 1));
    assign j_last = (j_reg == JW'(P - 1));
    assign i_last = (i_reg == IW'(M - 1));
    assign last   = k_last && j_last && i_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            k_reg      <= '0;
            j_reg      <= '0;
            i_reg      <= '0;
            a_addr_reg <= '0;
            a_base_reg <= '0;
            x_addr_reg <= '0;
        end else if (adv) begin
            if (!k_last) begin
                k_reg      <= k_reg + 1'b1;
                a_addr_reg <= a_addr_reg + 1'b1;
                x_addr_reg <= x_addr_reg + XW'(XSTEP);
            end else begin
                k_reg <= '0;
                if (!j_last) begin
                    // Same A row again; X moves to the next column.
                    j_reg      <= j_reg + 1'b1;
                    a_addr_reg <= a_base_reg;
`ifdef MXM_FEED_XCOL_EN
                    x_addr_reg <= x_addr_reg + 1'b1;
`else
                    x_addr_reg <= XW'(j_reg) + XW'(1);
`endif
                end else begin
                    j_reg      <= '0;
                    x_addr_reg <= '0;
                    if (i_last) begin
                        i_reg      <= '0;
                        a_addr_reg <= '0;
                        a_base_reg <= '0;
                    end else begin
                        i_reg      <= i_reg + 1'b1;
                        a_addr_reg <= a_addr_reg + 1'b1;
                        a_base_reg <= a_addr_reg + 1'b1;
                    end
                end
            end
        end
    end

    assign a_addr = a_addr_reg;
    assign x_addr = x_addr_reg;
    assign i      = i_reg;
    assign j      = j_reg;

endmodule

// File: rtl/mxm_operand_feeder.sv
// Operand sequencer for the MxM stage: streams A/X pairs phase-locked to MxM's mod-N counter and
// tags each finished dot product with (row, col). MXM_FEED_XCOL_EN switches X to column-major.
module mxm_operand_feeder
    import mxm_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int P = P_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   a_rd,
    output logic [log2(M*N)-1:0]   a_addr,
    input  logic [W-1:0]           a_rdata,
    output logic                   x_rd,
    output logic [log2(N*P)-1:0]   x_addr,
    input  logic [W-1:0]           x_rdata,
    output logic [W-1:0]           A,
    output logic [W-1:0]           X,
    output logic                   y_valid,
    output logic [log2(M)-1:0]     y_row,
    output logic [log2(P)-1:0]     y_col
);

    localparam int AW = log2(M * N);
    localparam int XW = log2(N * P);
    localparam int IW = log2(M);
    localparam int JW = log2(P);
    localparam int PW = log2(N);

    feed_state_t   state_reg;
    feed_state_t   state_next;
    logic [PW-1:0] ph_reg;
    logic          ph_last;

    logic          a_rd_reg, a_rd_next;
    logic          busy_reg, busy_next;
    logic          done_reg;
    logic          pres_reg;
    logic          pres_kl_reg;
    logic          pres_last_reg;
    logic [IW-1:0] pres_i_reg;
    logic [JW-1:0] pres_j_reg;
    logic          y_valid_reg;
    logic [IW-1:0] y_row_reg;
    logic [JW-1:0] y_col_reg;

    logic [AW-1:0] cnt_a_addr;
    logic [XW-1:0] cnt_x_addr;
    logic [IW-1:0] cnt_i;
    logic [JW-1:0] cnt_j;
    logic          cnt_k_last;
    logic          cnt_last;

    assign ph_last = (ph_reg == PW'(N - 1));

    // Free-running phase, an exact copy of MxM's n counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_reg <= '0;
        end else begin
            ph_reg <= ph_last ? '0 : ph_reg + 1'b1;
        end
    end

    mxm_idx_counter #(
        .N (N),
        .M (M),
        .P (P),
        .AW(AW),
        .XW(XW),
        .IW(IW),
        .JW(JW),
        .KW(PW)
    ) u_idx (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_reg == IDLE),
        .adv   (a_rd_reg),
        .a_addr(cnt_a_addr),
        .x_addr(cnt_x_addr),
        .i     (cnt_i),
        .j     (cnt_j),
        .k_last(cnt_k_last),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The done cycle is already IDLE, so done_reg blocks a start sampled in that cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && !done_reg) state_next = ARMED;
            ARMED:   if (ph_last) state_next = RUN;
            RUN:     if (cnt_last) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_rd_next = (state_next == RUN);
        busy_next = (state_next != IDLE);
    end

    // Tags ride along with each read: read cycle -> presentation cycle -> y_valid cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rd_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            pres_reg      <= 1'b0;
            pres_kl_reg   <= 1'b0;
            pres_last_reg <= 1'b0;
            pres_i_reg    <= '0;
            pres_j_reg    <= '0;
            y_valid_reg   <= 1'b0;
            y_row_reg     <= '0;
            y_col_reg     <= '0;
        end else begin
            a_rd_reg      <= a_rd_next;
            busy_reg      <= busy_next;
            pres_reg      <= a_rd_reg;
            pres_kl_reg   <= a_rd_reg && cnt_k_last;
            pres_last_reg <= a_rd_reg && cnt_last;
            pres_i_reg    <= cnt_i;
            pres_j_reg    <= cnt_j;
            y_valid_reg   <= pres_kl_reg;
            y_row_reg     <= pres_kl_reg ? pres_i_reg : '0;
            y_col_reg     <= pres_kl_reg ? pres_j_reg : '0;
            done_reg      <= pres_last_reg;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign a_rd    = a_rd_reg;
    assign x_rd    = a_rd_reg;
    assign a_addr  = cnt_a_addr;
    assign x_addr  = cnt_x_addr;
    assign A       = pres_reg ? a_rdata : '0;
    assign X       = pres_reg ? x_rdata : '0;
    assign y_valid = y_valid_reg;
    assign y_row   = y_row_reg;
    assign y_col   = y_col_reg;

endmodule
